demux_rr_ctrl: RTL and testbench

Round-robin scheduler that drives a 1-to-4 demux. It accepts a single input stream through a valid/ready handshake and holds each word in a one-entry register. It picks the destination channel, drives the demux select and per-channel valid, and moves to the next channel once the word is delivered. It sits between the upstream producer and four downstream consumers; the selected channel's data path is the existing combinational demux.

---
 rtl/demux_rr_ctrl_pkg.sv | 27 ++
 rtl/demux_rr_ctrl_rr_pick.sv | 53 +++++
 rtl/demux_rr_ctrl.sv | 139 +++++++++++++
 tb/tb_demux_rr_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/demux_rr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants, state encoding and select decode for the
//               round-robin demux scheduler (demux_rr_ctrl and rr_pick).
// Contents    : NUM_CH, SEL_W, state_t {ST_EMPTY, ST_FULL}, sel_to_onehot()
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
      logic [NUM_CH-1:0] oh;
      oh      = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_rr_ctrl_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin scan. Starting at ptr and walking
//               ptr, ptr+1, ptr+2, ptr+3 (mod 4) it reports:
//                 - the first channel that is masked in AND ready
//                 - the first channel that is masked in
//               When nothing qualifies the select falls back to ptr with
//               the corresponding found flag low.
// Ports       : ptr         - rotation start point
//               cfg_mask    - per-channel enable
//               d_out_ready - per-channel consumer ready
//               rdy_sel/rdy_found - first enabled and ready channel
//               msk_sel/msk_found - first enabled channel
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0]  ptr,
   input  logic [NUM_CH-1:0] cfg_mask,
   input  logic [NUM_CH-1:0] d_out_ready,
   output logic [SEL_W-1:0]  rdy_sel,
   output logic              rdy_found,
   output logic [SEL_W-1:0]  msk_sel,
   output logic              msk_found
);

   logic [SEL_W-1:0] w_idx;

   // Walk from the farthest offset back to ptr so the closest qualifying
   // channel is the one left standing.
   always_comb begin
      rdy_sel   = ptr;
      rdy_found = 1'b0;
      msk_sel   = ptr;
      msk_found = 1'b0;
      w_idx     = ptr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         w_idx = ptr + SEL_W'(k);
         if (cfg_mask[w_idx]) begin
            msk_sel   = w_idx;
            msk_found = 1'b1;
         end
         if (cfg_mask[w_idx] && d_out_ready[w_idx]) begin
            rdy_sel   = w_idx;
            rdy_found = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/demux_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_ctrl
// Description : Round-robin scheduler for a 1-to-4 demux. Accepts one word
//               at a time through a valid/ready handshake into a one-entry
//               holding register, selects the destination channel, drives
//               the demux select and one-hot per-channel valid, and rotates
//               to the next channel after each delivery. Full throughput:
//               a word can be delivered and the next one captured on the
//               same edge.
// Config      : DEMUX_RR_SKIP_EN defined   -> work-conserving selection
//                                              (skip stalled/masked channels)
//               DEMUX_RR_SKIP_EN undefined -> strict rotation (default)
// Parameters  : DATA_W - data word width
//               CNT_W  - delivered-word counter width (wraps silently)
// Ports       : clk, rst (async, active-high)
//               en, cfg_mask            - scheduler enable, channel mask
//               d_in, d_in_valid/ready  - upstream handshake
//               d_sel, d_out            - demux select and held word
//               d_out_valid/ready       - per-channel downstream handshake
//               busy, word_cnt          - occupancy and delivery count
// Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_ctrl
   import demux_pkg::*;
#(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] cfg_mask,
   input  logic [DATA_W-1:0] d_in,
   input  logic              d_in_valid,
   output logic              d_in_ready,
   output logic [SEL_W-1:0]  d_sel,
   output logic [DATA_W-1:0] d_out,
   output logic [NUM_CH-1:0] d_out_valid,
   input  logic [NUM_CH-1:0] d_out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  word_cnt
);

   state_t            r_state, w_state_nxt;
   logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

   logic              w_full;
   logic [SEL_W-1:0]  w_sel;
   logic              w_sel_en;    // channel under w_sel is masked in
   logic              w_can_go;    // channel under w_sel is masked in and ready
   logic              w_deliver;
   logic              w_capture;

   logic [SEL_W-1:0]  w_rdy_sel;
   logic              w_rdy_found;
   logic [SEL_W-1:0]  w_msk_sel;
   logic              w_msk_found;

   assign w_full = (r_state == ST_FULL);

   rr_pick u_rr_pick (
      .ptr         (r_ptr),
      .cfg_mask    (cfg_mask),
      .d_out_ready (d_out_ready),
      .rdy_sel     (w_rdy_sel),
      .rdy_found   (w_rdy_found),
      .msk_sel     (w_msk_sel),
      .msk_found   (w_msk_found)
   );

`ifdef DEMUX_RR_SKIP_EN
   // Work-conserving: go to the first ready channel from ptr; if none is
   // ready, park on the first enabled one. Only the select may move while
   // stalled, the held word never does.
   assign w_sel    = !w_full    ? r_ptr     :
                     w_rdy_found ? w_rdy_sel : w_msk_sel;
   assign w_sel_en = w_msk_found;
   assign w_can_go = w_rdy_found;
`else
   // Strict rotation: the select is always ptr. The scan result is only
   // useful here when the first qualifying channel is ptr itself.
   assign w_sel    = r_ptr;
   assign w_sel_en = w_msk_found && (w_msk_sel == r_ptr);
   assign w_can_go = w_rdy_found && (w_rdy_sel == r_ptr);
`endif

   assign w_deliver  = w_full && en && w_can_go;
   // rst gates ready so upstream never sees an accept while in reset.
   assign d_in_ready = !rst && en && (!w_full || w_deliver);
   assign w_capture  = d_in_valid && d_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_ptr   <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_data  <= w_data_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;

      if (w_deliver) begin
         w_ptr_nxt   = w_sel + SEL_W'(1);
         w_cnt_nxt   = r_cnt + CNT_W'(1);
         w_state_nxt = ST_EMPTY;
      end else if (w_full && en && !cfg_mask[r_ptr]) begin
         // Step off a masked-out channel one position per cycle; this also
         // keeps ptr rotating when the whole mask is clear.
         w_ptr_nxt = r_ptr + SEL_W'(1);
      end

      // Capture after delivery so a same-edge deliver+capture stays FULL.
      if (w_capture) begin
         w_data_nxt  = d_in;
         w_state_nxt = ST_FULL;
      end
   end

   assign d_sel       = w_sel;
   assign d_out       = r_data;
   assign d_out_valid = (w_full && w_sel_en) ? sel_to_onehot(w_sel) : '0;
   assign busy        = w_full;
   assign word_cnt    = r_cnt;

endmodule : demux_rr_ctrl
`default_nettype wire

// File: tb/tb_demux_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_rr_ctrl
// Description : Directed self-checking bench for demux_rr_ctrl in its default
//               strict-rotation build. A second instance with CNT_W=2 shares
//               all inputs to exercise counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b1;
   logic [3:0] cfg_mask = 4'hF;
   logic [0:0] d_in = 1'b0;
   logic       d_in_valid = 1'b0;
   logic [3:0] d_out_ready = 4'hF;

   logic       d_in_ready;
   logic [1:0] d_sel;
   logic [0:0] d_out;
   logic [3:0] d_out_valid;
   logic       busy;
   logic [7:0] word_cnt;

   logic       d2_in_ready;
   logic [1:0] d2_sel;
   logic [0:0] d2_out;
   logic [3:0] d2_out_valid;
   logic       d2_busy;
   logic [1:0] d2_word_cnt;

   int total = 0;
   int bad   = 0;

   logic [1:0] exp2 [4];

   demux_rr_ctrl #(.DATA_W(1), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg_mask    (cfg_mask),
      .d_in        (d_in),
      .d_in_valid  (d_in_valid),
      .d_in_ready  (d_in_ready),
      .d_sel       (d_sel),
      .d_out       (d_out),
      .d_out_valid (d_out_valid),
      .d_out_ready (d_out_ready),
      .busy        (busy),
      .word_cnt    (word_cnt)
   );

   demux_rr_ctrl #(.DATA_W(1), .CNT_W(2)) dut2 (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg_mask    (cfg_mask),
      .d_in        (d_in),
      .d_in_valid  (d_in_valid),
      .d_in_ready  (d2_in_ready),
      .d_sel       (d2_sel),
      .d_out       (d2_out),
      .d_out_valid (d2_out_valid),
      .d_out_ready (d_out_ready),
      .busy        (d2_busy),
      .word_cnt    (d2_word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      exp2[0] = 2'd2; exp2[1] = 2'd3; exp2[2] = 2'd0; exp2[3] = 2'd1;

      // ---------------- reset ----------------
      #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("rst_ready", d_in_ready, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_valid", d_out_valid, 0);
      chk("rst_cnt",   word_cnt, 0);
      chk("rst_sel",   d_sel, 0);
      chk("rst_dout",  d_out, 0);
      rst = 1'b0;

      // ---------------- stream 1,0,1,1 at full rate ----------------
      d_in = 1'b1; d_in_valid = 1'b1; #1;
      chk("s_ready_empty", d_in_ready, 1);
      @(negedge clk); d_in = 1'b0; #1;
      chk("s_v0", d_out_valid, 4'b0001); chk("s_d0", d_out, 1); chk("s_r0", d_in_ready, 1);
      @(negedge clk); d_in = 1'b1; #1;
      chk("s_v1", d_out_valid, 4'b0010); chk("s_d1", d_out, 0); chk("s_c1", word_cnt, 1);
      chk("s_r1", d_in_ready, 1);
      @(negedge clk); d_in = 1'b1; #1;
      chk("s_v2", d_out_valid, 4'b0100); chk("s_d2", d_out, 1); chk("s_c2", word_cnt, 2);
      @(negedge clk); d_in_valid = 1'b0; #1;
      chk("s_v3", d_out_valid, 4'b1000); chk("s_d3", d_out, 1); chk("s_c3", word_cnt, 3);
      chk("s_r3", d_in_ready, 1);
      @(negedge clk); #1;
      chk("s_busy", busy, 0); chk("s_c4", word_cnt, 4); chk("s_vend", d_out_valid, 0);

      // ---------------- stall on channel 1 ----------------
      d_out_ready = 4'b1101; d_in = 1'b1; d_in_valid = 1'b1;
      @(negedge clk); d_in = 1'b0; #1;
      chk("st_v0", d_out_valid, 4'b0001); chk("st_d0", d_out, 1);
      @(negedge clk); d_in = 1'b1; #1;
      chk("st_v1", d_out_valid, 4'b0010); chk("st_d1", d_out, 0);
      chk("st_rdy", d_in_ready, 0); chk("st_c", word_cnt, 5);
      repeat (3) begin
         @(negedge clk); #1;
         chk("st_hold_v", d_out_valid, 4'b0010); chk("st_hold_d", d_out, 0);
         chk("st_hold_r", d_in_ready, 0); chk("st_hold_c", word_cnt, 5);
         chk("st_hold_s", d_sel, 1);
      end
      d_in_valid = 1'b0; d_out_ready = 4'hF; #1;
      chk("st_release_r", d_in_ready, 1);
      @(negedge clk); #1;
      chk("st_busy", busy, 0); chk("st_c6", word_cnt, 6);

      // ---------------- mask 0101, four words (ptr starts at 2) ----------------
      cfg_mask = 4'b0101; d_in = 1'b1; d_in_valid = 1'b1;
      @(negedge clk); d_in = 1'b0; #1;
      chk("m_v_a", d_out_valid, 4'b0100); chk("m_d_a", d_out, 1); chk("m_r_a", d_in_ready, 1);
      @(negedge clk); #1;
      chk("m_v_b", d_out_valid, 0); chk("m_r_b", d_in_ready, 0); chk("m_c7", word_cnt, 7);
      @(negedge clk); d_in = 1'b1; #1;
      chk("m_v_c", d_out_valid, 4'b0001); chk("m_d_c", d_out, 0);
      @(negedge clk); #1;
      chk("m_v_d", d_out_valid, 0); chk("m_c8", word_cnt, 8);
      @(negedge clk); #1;
      chk("m_v_e", d_out_valid, 4'b0100); chk("m_d_e", d_out, 1);
      @(negedge clk); d_in_valid = 1'b0; #1;
      chk("m_v_f", d_out_valid, 0); chk("m_c9", word_cnt, 9);
      @(negedge clk); #1;
      chk("m_v_g", d_out_valid, 4'b0001); chk("m_d_g", d_out, 1);
      @(negedge clk); #1;
      chk("m_busy", busy, 0); chk("m_c10", word_cnt, 10);

      // ---------------- mask 0000 hold, then 1000 ----------------
      cfg_mask = 4'b0000; d_in = 1'b1; d_in_valid = 1'b1;
      @(negedge clk); d_in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("z_busy", busy, 1); chk("z_valid", d_out_valid, 0);
         @(negedge clk);
      end
      cfg_mask = 4'b1000; #1;
      chk("z_v3", d_out_valid, 4'b1000); chk("z_sel3", d_sel, 3); chk("z_c", word_cnt, 10);
      @(negedge clk); #1;
      chk("z_c11", word_cnt, 11); chk("z_busy_end", busy, 0);

      // ---------------- async reset mid-word ----------------
      cfg_mask = 4'hF; d_out_ready = 4'h0; d_in = 1'b1; d_in_valid = 1'b1;
      @(negedge clk); d_in_valid = 1'b0; #1;
      chk("r_v_pre", d_out_valid, 4'b0001); chk("r_busy_pre", busy, 1);
      #2 rst = 1'b1; #1;
      chk("r_valid", d_out_valid, 0); chk("r_busy", busy, 0); chk("r_cnt", word_cnt, 0);
      chk("r_ready", d_in_ready, 0); chk("r_dout", d_out, 0); chk("r_cnt2", d2_word_cnt, 0);
      @(negedge clk); rst = 1'b0; d_out_ready = 4'hF; d_in = 1'b0; d_in_valid = 1'b1;
      @(negedge clk); d_in_valid = 1'b0; #1;
      chk("r_first_v", d_out_valid, 4'b0001); chk("r_first_s", d_sel, 0);
      @(negedge clk); #1;
      chk("r_c1", word_cnt, 1); chk("w_c2_1", d2_word_cnt, 1); chk("r_busy_end", busy, 0);

      // ---------------- counter wrap on CNT_W=2 ----------------
      d_in = 1'b1; d_in_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("w_cnt8", word_cnt, 32'(i + 2));
         chk("w_cnt2", d2_word_cnt, exp2[i]);
      end

      // ---------------- enable low with a word held ----------------
      en = 1'b0; #1;
      chk("e_ready", d_in_ready, 0); chk("e_valid", d_out_valid, 4'b0010);
      @(negedge clk); #1;
      chk("e_cnt", word_cnt, 5); chk("e_valid2", d_out_valid, 4'b0010);
      chk("e_busy", busy, 1); chk("e_dout", d_out, 1);
      en = 1'b1; d_in_valid = 1'b0;
      @(negedge clk); #1;
      chk("e_cnt6", word_cnt, 6); chk("e_cnt2", d2_word_cnt, 2); chk("e_busy_end", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux_rr_ctrl
`default_nettype wire
